// File: rtl/sum_ctrl.sv
// sum_ctrl: sequences paired reads from two FIFOs into a registered adder and
// hands each sum to a consumer with a valid/ready handshake. A pass produces
// col sums indexed 0..col-1. Moore outputs are decoded from the registered
// state and index only.
module sum_ctrl #(
  parameter int col    = 8,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fifo1_empty,
  input  logic              fifo2_empty,
  output logic              fifo1_rd,
  output logic              fifo2_rd,
  output logic              add_inst,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [cnt_bw-1:0] sum_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_READ = 3'd2,
    S_ADD  = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  // Index of the final sum in a pass.
  localparam logic [cnt_bw-1:0] last_idx = cnt_bw'(col - 1);

  state_e              state_q, state_d;
  logic [cnt_bw-1:0]   sum_idx_q, sum_idx_d;
  logic                done_q, done_d;

  // Next-state and next-index decision; emptiness only matters in WAIT and
  // start only in IDLE, so both are ignored everywhere else.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    sum_idx_d = sum_idx_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WAIT;
          sum_idx_d = '0;
        end
      end
      S_WAIT: begin
        if (!fifo1_empty && !fifo2_empty) begin
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_ADD;
      S_ADD:  state_d = S_HOLD;
      S_HOLD: begin
        if (sum_ready) begin
          if (sum_idx_q == last_idx) begin
            // Last sum accepted: the index is held and done pulses once.
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_WAIT;
            sum_idx_d = sum_idx_q + cnt_bw'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, index and done-pulse registers with synchronous reset priority.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      sum_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_idx_q <= sum_idx_d;
      done_q    <= done_d;
    end
  end

  // Moore output decode from registered state only.
  always_comb begin
    fifo1_rd  = (state_q == S_READ);
    fifo2_rd  = (state_q == S_READ);
    add_inst  = (state_q == S_ADD);
    sum_valid = (state_q == S_HOLD);
    busy      = (state_q != S_IDLE);
    done      = done_q;
    sum_idx   = sum_idx_q;
  end

endmodule
